intersection_sensor_model: RTL and testbench

- Closed-loop counterpart of the two-street light controller.
- Consumes the La/Lb light codes and car-arrival pulses, keeps a vehicle queue per street, and drives the Ta/Tb traffic sensors back to the controller.
- Also checks each light-code stream for illegal codes, illegal sequences and cross-street conflicts, and raises a sticky error with the first error code.
- Used as the intersection model in system-level simulation and as an on-chip safety monitor.

---
 rtl/intersection_sensor_model_pkg.sv | 29 ++
 rtl/intersection_sensor_model_light_seq_tracker.sv | 48 ++++
 rtl/intersection_sensor_model.sv | 108 ++++++++++
 tb/tb_intersection_sensor_model.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/intersection_sensor_model_pkg.sv
// Shared constants and types for the intersection sensor model.
package intersection_sensor_model_pkg;

    // Light codes driven by the controller
    localparam logic [2:0] LIGHT_GREEN  = 3'b111;
    localparam logic [2:0] LIGHT_YELLOW = 3'b100;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    // Tracker state: the legal code sampled at the previous edge, or UNK
    typedef enum logic [1:0] {
        TRK_UNK = 2'd0,
        TRK_GRN = 2'd1,
        TRK_YEL = 2'd2,
        TRK_RED = 2'd3
    } trk_state_t;

    // Error codes; lower value wins when several fire on the same edge
    localparam logic [2:0] ERR_NONE     = 3'b000;
    localparam logic [2:0] ERR_CODE_A   = 3'b001;
    localparam logic [2:0] ERR_CODE_B   = 3'b010;
    localparam logic [2:0] ERR_TRANS_A  = 3'b011;
    localparam logic [2:0] ERR_TRANS_B  = 3'b100;
    localparam logic [2:0] ERR_CONFLICT = 3'b101;

    function automatic logic is_legal(input logic [2:0] c);
        return (c == LIGHT_GREEN) || (c == LIGHT_YELLOW) || (c == LIGHT_RED);
    endfunction

endpackage

// File: rtl/intersection_sensor_model_light_seq_tracker.sv
// Per-street light sequence tracker: remembers the last legal code and
// flags illegal codes and illegal transitions on the current sample.
module light_seq_tracker
    import intersection_sensor_model_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    output trk_state_t state,
    output logic       code_err,
    output logic       trans_err
);

    trk_state_t state_next;

    // State register; reset returns to UNK so the first sample is never a transition error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= TRK_UNK;
        else      state <= state_next;
    end

    // Next state and error decode for the current sample
    always_comb begin
        state_next = state;
        code_err   = 1'b0;
        trans_err  = 1'b0;
        case (code)
            LIGHT_GREEN: begin
                state_next = TRK_GRN;
                trans_err  = (state == TRK_YEL);
            end
            LIGHT_YELLOW: begin
                state_next = TRK_YEL;
                trans_err  = (state == TRK_YEL) || (state == TRK_RED);
            end
            LIGHT_RED: begin
                state_next = TRK_RED;
                trans_err  = (state == TRK_GRN);
            end
            default: begin
                // Illegal code: forget history so the next legal code is accepted
                state_next = TRK_UNK;
                code_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/intersection_sensor_model.sv
// Intersection model: per-street vehicle queues driving Ta/Tb, plus a
// sticky safety monitor over the La/Lb light code streams.
module intersection_sensor_model
    import intersection_sensor_model_pkg::*;
#(
    parameter int Q_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     La,
    input  logic [2:0]     Lb,
    input  logic           arr_a,
    input  logic           arr_b,
    output logic           Ta,
    output logic           Tb,
    output logic [Q_W-1:0] qa,
    output logic [Q_W-1:0] qb,
    output logic           err,
    output logic [2:0]     err_code
);

    localparam logic [Q_W-1:0] Q_MAX = {Q_W{1'b1}};

    trk_state_t     st_a, st_b;
    logic           code_err_a, trans_err_a, code_err_b, trans_err_b;
    logic           conflict;
    logic           err_now;
    logic [2:0]     err_sel;
    logic [Q_W-1:0] qa_next, qb_next;

    // One car leaves per green cycle; arrivals at a full queue with no
    // departure are dropped so the counter saturates instead of wrapping.
    function automatic logic [Q_W-1:0] q_step(input logic [Q_W-1:0] q,
                                               input logic [2:0]     code,
                                               input logic           arr);
        logic dep, inc;
        dep = (code == LIGHT_GREEN) && (q != '0);
        inc = arr && !((q == Q_MAX) && !dep);
        if (inc && !dep)      return q + Q_W'(1);
        else if (dep && !inc) return q - Q_W'(1);
        else                  return q;
    endfunction

    light_seq_tracker u_trk_a (
        .clk       (clk),
        .rst       (rst),
        .code      (La),
        .state     (st_a),
        .code_err  (code_err_a),
        .trans_err (trans_err_a)
    );

    light_seq_tracker u_trk_b (
        .clk       (clk),
        .rst       (rst),
        .code      (Lb),
        .state     (st_b),
        .code_err  (code_err_b),
        .trans_err (trans_err_b)
    );

    // Queue next-state per street
    always_comb begin
        qa_next = q_step(qa, La, arr_a);
        qb_next = q_step(qb, Lb, arr_b);
    end

    // Queue counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qa <= '0;
            qb <= '0;
        end else begin
            qa <= qa_next;
            qb <= qb_next;
        end
    end

    // Sensors decode registered counts only, so no input reaches an output combinationally
    assign Ta = (qa != '0);
    assign Tb = (qb != '0);

    // Error detection for this sample, lowest code first
    always_comb begin
        conflict = is_legal(La) && is_legal(Lb) &&
                   (La != LIGHT_RED) && (Lb != LIGHT_RED);
        err_now  = 1'b1;
        err_sel  = ERR_NONE;
        if      (code_err_a)  err_sel = ERR_CODE_A;
        else if (code_err_b)  err_sel = ERR_CODE_B;
        else if (trans_err_a) err_sel = ERR_TRANS_A;
        else if (trans_err_b) err_sel = ERR_TRANS_B;
        else if (conflict)    err_sel = ERR_CONFLICT;
        else                  err_now = 1'b0;
    end

    // Sticky capture of the first error; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (!err && err_now) begin
            err      <= 1'b1;
            err_code <= err_sel;
        end
    end

endmodule

// File: tb/tb_intersection_sensor_model.sv
// Directed bench for intersection_sensor_model with a reference model feeding a scoreboard.
module tb_intersection_sensor_model;
    import intersection_sensor_model_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] La = 3'b111, Lb = 3'b001;
    logic       arr_a = 1'b0, arr_b = 1'b0;
    logic       Ta, Tb, err;
    logic [3:0] qa, qb;
    logic [2:0] err_code;

    intersection_sensor_model #(.Q_W(4)) dut (
        .clk(clk), .rst(rst), .La(La), .Lb(Lb), .arr_a(arr_a), .arr_b(arr_b),
        .Ta(Ta), .Tb(Tb), .qa(qa), .qb(qb), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails = 0;

    // Reference model state; prev code 000 stands for "unknown"
    int       m_qa = 0, m_qb = 0;
    logic [2:0] m_pa = 3'b000, m_pb = 3'b000;
    logic       m_err = 1'b0;
    logic [2:0] m_code = 3'b000;

    function automatic bit legal(input logic [2:0] c);
        return c == 3'b111 || c == 3'b100 || c == 3'b001;
    endfunction

    function automatic bit trans_ok(input logic [2:0] p, input logic [2:0] c);
        if (p == 3'b000) return 1;
        if (p == 3'b111) return c == 3'b111 || c == 3'b100;
        if (p == 3'b100) return c == 3'b001;
        return c == 3'b001 || c == 3'b111;
    endfunction

    function automatic int q_model(input int q, input logic [2:0] c, input logic arr);
        if (c == 3'b111 && q > 0) return arr ? q : q - 1;
        if (arr && q < 15) return q + 1;
        return q;
    endfunction

    function automatic logic [13:0] pack_exp();
        return {m_qa[3:0], m_qb[3:0], m_qa != 0, m_qb != 0, m_err, m_code};
    endfunction

    task automatic model_update(input logic [2:0] la, input logic [2:0] lb,
                                input logic aa, input logic ab);
        logic [2:0] c;
        c = 3'b000;
        if      (!legal(la))                 c = 3'b001;
        else if (!legal(lb))                 c = 3'b010;
        else if (!trans_ok(m_pa, la))        c = 3'b011;
        else if (!trans_ok(m_pb, lb))        c = 3'b100;
        else if (la != 3'b001 && lb != 3'b001) c = 3'b101;
        if (!m_err && c != 3'b000) begin
            m_err  = 1'b1;
            m_code = c;
        end
        m_pa = legal(la) ? la : 3'b000;
        m_pb = legal(lb) ? lb : 3'b000;
        m_qa = q_model(m_qa, la, aa);
        m_qb = q_model(m_qb, lb, ab);
    endtask

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus, queue the model's prediction, compare after the edge
    task automatic step(input logic [2:0] la, input logic [2:0] lb,
                        input logic aa, input logic ab, input string tag);
        exp_t e;
        @(negedge clk);
        rst = 1'b1; La = la; Lb = lb; arr_a = aa; arr_b = ab;
        model_update(la, lb, aa, ab);
        sb.push_back('{pack_exp(), tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, {qa, qb, Ta, Tb, err, err_code}, e.v);
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock
    task automatic do_reset(input logic [2:0] la, input logic [2:0] lb, input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0; La = la; Lb = lb; arr_a = 1'b0; arr_b = 1'b0;
        #1;
        check(tag, {qa, qb, Ta, Tb, err, err_code}, 14'h0000);
        m_qa = 0; m_qb = 0; m_pa = 3'b000; m_pb = 3'b000;
        m_err = 1'b0; m_code = 3'b000;
        @(posedge clk);
    endtask

    initial begin
        do_reset(3'b111, 3'b001, "reset_init");

        // Arrivals on B while B is red
        for (int i = 0; i < 3; i++) step(3'b111, 3'b001, 1'b0, 1'b1, "arr_b_fill");

        // Build qa=2 through yellow/red, then arrival+departure, then drain
        step(3'b100, 3'b001, 1'b1, 1'b0, "qa_fill_yel");
        step(3'b001, 3'b001, 1'b1, 1'b0, "qa_fill_red");
        step(3'b111, 3'b001, 1'b1, 1'b0, "qa_arr_dep");
        step(3'b111, 3'b001, 1'b0, 1'b0, "qa_dep1");
        step(3'b111, 3'b001, 1'b0, 1'b0, "qa_dep_empty");

        // Saturate qb
        for (int i = 0; i < 17; i++) step(3'b111, 3'b001, 1'b0, 1'b1, "qb_sat");
        step(3'b100, 3'b001, 1'b0, 1'b1, "qb_sat_yel");
        step(3'b001, 3'b001, 1'b0, 1'b1, "qb_sat_red");
        step(3'b001, 3'b111, 1'b0, 1'b1, "qb_full_arr_dep");
        step(3'b001, 3'b111, 1'b0, 1'b0, "qb_full_dep");
        step(3'b001, 3'b100, 1'b0, 1'b0, "b_to_yel");

        // Legal alternating sequence
        step(3'b111, 3'b001, 1'b0, 1'b0, "legal_0");
        step(3'b100, 3'b001, 1'b0, 1'b0, "legal_1");
        step(3'b001, 3'b111, 1'b0, 1'b0, "legal_2");
        step(3'b001, 3'b100, 1'b0, 1'b0, "legal_3");
        step(3'b111, 3'b001, 1'b0, 1'b0, "legal_4");

        // Transition error then a later conflict that must not overwrite it
        step(3'b001, 3'b001, 1'b0, 1'b0, "trans_a_err");
        step(3'b111, 3'b111, 1'b0, 1'b0, "sticky_hold");

        // Mid-operation reset clears the sticky error, then a conflict from UNK
        do_reset(3'b111, 3'b111, "reset_mid");
        step(3'b111, 3'b111, 1'b0, 1'b0, "conflict_err");

        // Bad code A and bad transition B together: lowest code wins
        do_reset(3'b111, 3'b001, "reset_prio");
        step(3'b111, 3'b001, 1'b0, 1'b0, "prio_setup");
        step(3'b010, 3'b100, 1'b0, 1'b0, "prio_code_a");
        step(3'b111, 3'b001, 1'b0, 1'b0, "recover_a");
        vectors++;
        assert (dut.st_a === TRK_GRN) else begin
            fails++;
            $error("FAIL trk_a_recover: observed %0d expected %0d", dut.st_a, TRK_GRN);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
